// File: rtl/alu_mdu_pkg.sv
// rtl/alu_mdu_pkg.sv - op codes, FSM states and op-class helpers shared by alu_mdu and its bench
package alu_mdu_pkg;

    localparam int OP_BITS = 5;
    typedef logic [OP_BITS-1:0] op_t;

    localparam op_t OP_NOP    = 5'd0;
    localparam op_t OP_LUI    = 5'd1;
    localparam op_t OP_AUIPC  = 5'd2;
    localparam op_t OP_ADD    = 5'd3;
    localparam op_t OP_SUB    = 5'd4;
    localparam op_t OP_SLT    = 5'd5;
    localparam op_t OP_SLTU   = 5'd6;
    localparam op_t OP_XOR    = 5'd7;
    localparam op_t OP_OR     = 5'd8;
    localparam op_t OP_AND    = 5'd9;
    localparam op_t OP_SLL    = 5'd10;
    localparam op_t OP_SRL    = 5'd11;
    localparam op_t OP_SRA    = 5'd12;
    localparam op_t OP_BEQ    = 5'd13;
    localparam op_t OP_BNE    = 5'd14;
    localparam op_t OP_BLT    = 5'd15;
    localparam op_t OP_BGE    = 5'd16;
    localparam op_t OP_BLTU   = 5'd17;
    localparam op_t OP_BGEU   = 5'd18;
    localparam op_t OP_MUL    = 5'd24;
    localparam op_t OP_MULH   = 5'd25;
    localparam op_t OP_MULHSU = 5'd26;
    localparam op_t OP_MULHU  = 5'd27;
    localparam op_t OP_DIV    = 5'd28;
    localparam op_t OP_DIVU   = 5'd29;
    localparam op_t OP_REM    = 5'd30;
    localparam op_t OP_REMU   = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_mul(input op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Operand A is treated as signed for MULH, MULHSU, DIV and REM; B only for MULH, DIV and REM.
    function automatic logic op_a_signed(input op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - iterative unsigned restoring divider, one quotient bit per cycle
module mdu_divider
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt;
    logic             running;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The partial remainder stays below the divisor, so one extra bit suffices for the trial subtract.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            rem_q   <= '0;
            quo_q   <= dividend;
            dsr_q   <= divisor;
            cnt     <= CW'(WIDTH);
            running <= 1'b1;
        end else if (running) begin
            if (diff[WIDTH]) begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                running <= 1'b0;
            end
        end
    end

    // High during the cycle whose closing edge performs the last iteration.
    assign done      = running && (cnt == CW'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - registered ALU plus iterative RV32M multiply/divide; MDU_FAST_MUL_EN selects a single-cycle multiply
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    op_t                opc;
    logic               accept;
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_zero, div_ovf, div_special;
    logic               go_mul, go_div;
    logic [WIDTH-1:0]   alu_res, imm_res, fin_res;
    logic               div_done;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] mcand, prod, prod_fix;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      iter;
    logic               neg_main, neg_r, hi_sel, rem_sel, from_div;

    assign opc      = op_t'(op);
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);

    // Mul/div run on magnitudes; the sign of the final result is restored at DONE.
    assign sgn_a = op_a_signed(opc) && a[WIDTH-1];
    assign sgn_b = op_b_signed(opc) && b[WIDTH-1];
    assign mag_a = sgn_a ? -a : a;
    assign mag_b = sgn_b ? -b : b;

    assign div_zero    = (b == '0);
    assign div_ovf     = ((opc == OP_DIV) || (opc == OP_REM)) && (a == MIN_VAL) && (b == '1);
    assign div_special = is_div(opc) && (div_zero || div_ovf);
    assign go_div      = is_div(opc) && !div_special;
`ifdef MDU_FAST_MUL_EN
    assign go_mul = 1'b0;
`else
    assign go_mul = is_mul(opc);
`endif

    always_comb begin
        alu_res = a + b;
        case (opc)
            OP_NOP:   alu_res = '0;
            OP_LUI:   alu_res = b;
            OP_AUIPC: alu_res = pc + b;
            OP_ADD:   alu_res = a + b;
            OP_SUB:   alu_res = a - b;
            OP_SLT:   alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU:  alu_res = WIDTH'(a < b);
            OP_XOR:   alu_res = a ^ b;
            OP_OR:    alu_res = a | b;
            OP_AND:   alu_res = a & b;
            OP_SLL:   alu_res = a << b[SHW-1:0];
            OP_SRL:   alu_res = a >> b[SHW-1:0];
            OP_SRA:   alu_res = $signed(a) >>> b[SHW-1:0];
            // Branch compares report the not-taken flag so that zero==1 means taken.
            OP_BEQ:   alu_res = WIDTH'(a != b);
            OP_BNE:   alu_res = WIDTH'(a == b);
            OP_BLT:   alu_res = WIDTH'(!($signed(a) < $signed(b)));
            OP_BGE:   alu_res = WIDTH'($signed(a) < $signed(b));
            OP_BLTU:  alu_res = WIDTH'(!(a < b));
            OP_BGEU:  alu_res = WIDTH'(a < b);
            default:  alu_res = a + b;
        endcase
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag, fast_fix;
    assign fast_mag = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    assign fast_fix = (sgn_a ^ sgn_b) ? -fast_mag : fast_mag;
`endif

    always_comb begin
        imm_res = alu_res;
        if (div_special) begin
            if (div_zero) begin
                imm_res = ((opc == OP_REM) || (opc == OP_REMU)) ? a : '1;
            end else begin
                imm_res = (opc == OP_REM) ? '0 : MIN_VAL;
            end
        end
`ifdef MDU_FAST_MUL_EN
        if (is_mul(opc)) begin
            imm_res = (opc == OP_MUL) ? fast_fix[WIDTH-1:0] : fast_fix[2*WIDTH-1:WIDTH];
        end
`endif
    end

    assign prod_fix = neg_main ? -prod : prod;

    always_comb begin
        fin_res = hi_sel ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
        if (from_div) begin
            if (rem_sel) begin
                fin_res = neg_r ? -rem : rem;
            end else begin
                fin_res = neg_main ? -quo : quo;
            end
        end
    end

    mdu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && go_div),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            iter      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            neg_main  <= 1'b0;
            neg_r     <= 1'b0;
            hi_sel    <= 1'b0;
            rem_sel   <= 1'b0;
            from_div  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (go_mul) begin
                            state    <= S_MUL;
                            iter     <= CW'(WIDTH);
                            mcand    <= {{WIDTH{1'b0}}, mag_a};
                            mplier   <= mag_b;
                            prod     <= '0;
                            neg_main <= sgn_a ^ sgn_b;
                            hi_sel   <= (opc != OP_MUL);
                            from_div <= 1'b0;
                        end else if (go_div) begin
                            state    <= S_DIV;
                            neg_main <= sgn_a ^ sgn_b;
                            neg_r    <= sgn_a;
                            rem_sel  <= (opc == OP_REM) || (opc == OP_REMU);
                            from_div <= 1'b1;
                        end else begin
                            result    <= imm_res;
                            zero      <= (imm_res == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    iter   <= iter - 1'b1;
                    if (iter == CW'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    result    <= fin_res;
                    zero      <= (fin_res == '0);
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
